frame_buffer_arbiter: RTL

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

---
 rtl/fb_pkg.sv | 15 +
 rtl/frame_buffer_arbiter_if.sv | 25 ++
 rtl/fb_addr_gen.sv | 53 +++++
 rtl/frame_buffer_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer arbiter: FSM state encoding and default geometry.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } fb_state_e;

    localparam int FB_ADDR_W        = 22;
    localparam int FB_FRAME_WORDS   = 307200;
    localparam int FB_BURST_LEN     = 8;
    localparam int FB_MAX_RD_STREAK = 4;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Bundle of the arbiter's FIFO-request and memory-bus signals, for benches and wrappers.
interface frame_buffer_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              rd_req;
    logic              wr_req;
    logic              frame_done;
    logic              wr_frame_start;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              rd_push;
    logic              wr_pop;

    modport master (
        input  rd_req, wr_req, frame_done, wr_frame_start, mem_ack,
        output mem_req, mem_we, mem_addr, rd_push, wr_pop
    );

    modport slave (
        output rd_req, wr_req, frame_done, wr_frame_start, mem_ack,
        input  mem_req, mem_we, mem_addr, rd_push, wr_pop
    );
endinterface

// File: rtl/fb_addr_gen.sv
// Burst address generator: base + beat counter, frame wrap, and a frame-start zeroing
// that is deferred to burst end when it lands mid-burst.
module fb_addr_gen #(
    parameter int CNT_W       = 21,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             ack,
    input  logic             zero_req,
    output logic [CNT_W-1:0] addr,
    output logic             done
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CNT_W-1:0]  base_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic              pend_reg;
    logic [CNT_W:0]    base_inc;

    assign done     = active & ack & (beat_reg == BEAT_W'(BURST_LEN - 1));
    assign base_inc = {1'b0, base_reg} + (CNT_W + 1)'(BURST_LEN);
    assign addr     = base_reg + CNT_W'(beat_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg <= '0;
            beat_reg <= '0;
            pend_reg <= 1'b0;
        end else begin
            if (active && ack) begin
                beat_reg <= done ? '0 : beat_reg + BEAT_W'(1);
            end
            if (done) begin
                // A zero request on the final beat counts as pending too.
                if (pend_reg || zero_req || (base_inc >= (CNT_W + 1)'(FRAME_WORDS))) begin
                    base_reg <= '0;
                end else begin
                    base_reg <= base_inc[CNT_W-1:0];
                end
                pend_reg <= 1'b0;
            end else if (zero_req) begin
                if (active) begin
                    pend_reg <= 1'b1;
                end else begin
                    base_reg <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Read/write burst arbiter for a shared frame buffer with a read-streak starvation guard.
// Optional bank swapping (MSB of the address) is enabled by defining FB_DOUBLE_BUFFER_EN.
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W        = FB_ADDR_W,
    parameter int FRAME_WORDS   = FB_FRAME_WORDS,
    parameter int BURST_LEN     = FB_BURST_LEN,
    parameter int MAX_RD_STREAK = FB_MAX_RD_STREAK
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRD_REQ,
    input  logic              iWR_REQ,
    input  logic              iFrameDone,
    input  logic              iWR_FRAME_START,
    input  logic              iMEM_ACK,
    output logic              oMEM_REQ,
    output logic              oMEM_WE,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oRD_PUSH,
    output logic              oWR_POP
);
    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

    fb_state_e             state_reg, state_next;
    logic [STREAK_W-1:0]   streak_reg, streak_next;
    logic                  bank;
    logic                  gen_active [2];
    logic                  gen_zero   [2];
    logic                  gen_done   [2];
    logic [ADDR_W-2:0]     gen_addr   [2];

    // Index 0 drives the display read stream, index 1 the camera write stream.
    assign gen_active[0] = (state_reg == ST_RD);
    assign gen_active[1] = (state_reg == ST_WR);
    assign gen_zero[0]   = iFrameDone;
    assign gen_zero[1]   = iWR_FRAME_START;

    for (genvar gi = 0; gi < 2; gi++) begin : g_addr
        fb_addr_gen #(
            .CNT_W       (ADDR_W - 1),
            .FRAME_WORDS (FRAME_WORDS),
            .BURST_LEN   (BURST_LEN)
        ) u_gen (
            .clk      (iCLK),
            .rst_n    (iRST_N),
            .active   (gen_active[gi]),
            .ack      (iMEM_ACK),
            .zero_req (gen_zero[gi]),
            .addr     (gen_addr[gi]),
            .done     (gen_done[gi])
        );
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg  <= ST_IDLE;
            streak_reg <= '0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        streak_next = streak_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!iWR_REQ) begin
                    streak_next = '0;
                end
                // The streak limit only matters when a write is actually waiting.
                if (iRD_REQ && (!iWR_REQ || (streak_reg < STREAK_W'(MAX_RD_STREAK)))) begin
                    state_next = ST_RD;
                    if (iWR_REQ) begin
                        streak_next = streak_reg + STREAK_W'(1);
                    end
                end else if (iWR_REQ) begin
                    state_next  = ST_WR;
                    streak_next = '0;
                end
            end
            ST_RD:   if (gen_done[0]) state_next = ST_IDLE;
            ST_WR:   if (gen_done[1]) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic wr_bank_reg, rd_bank_reg, burst_bank_reg;

    // The burst bank is frozen at grant so a mid-burst frame pulse cannot move a burst.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b0;
            burst_bank_reg <= 1'b0;
        end else begin
            if (iWR_FRAME_START) wr_bank_reg <= ~wr_bank_reg;
            if (iFrameDone)      rd_bank_reg <= ~wr_bank_reg;
            if (state_reg == ST_IDLE) begin
                burst_bank_reg <= (state_next == ST_WR) ? wr_bank_reg : rd_bank_reg;
            end
        end
    end
    assign bank = burst_bank_reg;
`else
    assign bank = 1'b0;
`endif

    assign oMEM_REQ = (state_reg != ST_IDLE);
    assign oMEM_WE  = (state_reg == ST_WR);
    assign oRD_PUSH = (state_reg == ST_RD) & iMEM_ACK;
    assign oWR_POP  = (state_reg == ST_WR) & iMEM_ACK;

    always_comb begin
        oMEM_ADDR = '0;
        if (state_reg == ST_RD) begin
            oMEM_ADDR = {bank, gen_addr[0]};
        end else if (state_reg == ST_WR) begin
            oMEM_ADDR = {bank, gen_addr[1]};
        end
    end
endmodule
